// File: rtl/am2940_word_counter_if.sv
// Am2940 word-count section bus: load/command inputs and count/DONE outputs.
interface am2940_word_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] di;
  logic [1:0]       mode;
  logic             ld;
  logic             reinit;
  logic             cnt;
  logic [WIDTH-1:0] wc;
  logic [WIDTH-1:0] wcr_q;
  logic             done;
  logic             done_flag;

  modport master (
    output di, mode, ld, reinit, cnt,
    input  wc, wcr_q, done, done_flag
  );

  modport slave (
    input  di, mode, ld, reinit, cnt,
    output wc, wcr_q, done, done_flag
  );
endinterface

// File: rtl/am2940_word_counter.sv
// Am2940 word count register/counter with mode-dependent counting and DONE.
module am2940_word_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  am2940_word_counter_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_DEC_WRAP = 2'd0,
    MODE_DEC_HOLD = 2'd1,
    MODE_INC      = 2'd2,
    MODE_INHIBIT  = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            w_mode;
  logic             w_done;
  logic [WIDTH-1:0] r_wc;
  logic [WIDTH-1:0] r_wcr;
  logic             r_done_flag;

  assign w_mode = mode_e'(bus.mode);

  // mode is used live each cycle; no internal copy is kept
  always_comb begin
    w_done = 1'b0;
    unique case (w_mode)
      MODE_DEC_WRAP: w_done = (r_wc == ONE);
      MODE_DEC_HOLD: w_done = (r_wc == '0);
      MODE_INC:      w_done = (r_wc == r_wcr);
      MODE_INHIBIT:  w_done = 1'b0;
      default:       w_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wc        <= '0;
      r_wcr       <= '0;
      r_done_flag <= 1'b0;
    end else if (bus.ld) begin
      r_wcr       <= bus.di;
      r_wc        <= (w_mode == MODE_INC) ? '0 : bus.di;
      r_done_flag <= 1'b0;
    end else if (bus.reinit) begin
      r_wc        <= (w_mode == MODE_INC) ? '0 : r_wcr;
      r_done_flag <= 1'b0;
    end else begin
      if (bus.cnt) begin
        unique case (w_mode)
          MODE_DEC_WRAP: r_wc <= r_wc - ONE;
          MODE_DEC_HOLD: r_wc <= (r_wc == '0) ? '0 : r_wc - ONE;
          MODE_INC:      r_wc <= r_wc + ONE;
          MODE_INHIBIT:  r_wc <= r_wc;
          default:       r_wc <= r_wc;
        endcase
      end
      if (w_done) r_done_flag <= 1'b1;
    end
  end

  assign bus.wc        = r_wc;
  assign bus.wcr_q     = r_wcr;
  assign bus.done      = w_done;
  assign bus.done_flag = r_done_flag;

endmodule
